// File: rtl/cached_memory_wb_arbiter_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter in front of
// the cached external-memory block.
package cached_memory_wb_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } arb_state_t;

  // Width of the response-timeout counter; TIMEOUT_CYCLES must fit in it.
  localparam int unsigned TMO_W = 8;

  typedef logic master_idx_t;

  localparam master_idx_t MASTER_0 = 1'b0;
  localparam master_idx_t MASTER_1 = 1'b1;

endpackage

// File: rtl/cached_memory_wb_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter. On a tie the master that did not complete
// the previous transaction wins; after reset master 0 wins the first tie.
module cached_memory_wb_arbiter_rr_arbiter2
  import cached_memory_wb_arbiter_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic        i_update,
  input  master_idx_t i_grant,
  output logic        o_valid,
  output master_idx_t o_winner
);

  master_idx_t r_last_grant;

  // Remember which master completed last; reset value favours master 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_grant <= MASTER_1;
    end else if (i_update) begin
      r_last_grant <= i_grant;
    end
  end

  // Pick the winner from the live requests.
  always_comb begin
    o_valid  = i_req0 | i_req1;
    o_winner = MASTER_0;
    if (i_req0 && i_req1) begin
      o_winner = (r_last_grant == MASTER_0) ? MASTER_1 : MASTER_0;
    end else if (i_req1) begin
      o_winner = MASTER_1;
    end
  end

endmodule

// File: rtl/cached_memory_wb_arbiter.sv
// Two-master Wishbone arbiter: one outstanding transaction, round-robin
// priority, response timeout, abort on owner cycle drop.
module cached_memory_wb_arbiter
  import cached_memory_wb_arbiter_pkg::*;
#(
  parameter int unsigned ADDRESS_SIZE   = 24,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,

  input  logic                    m0_wb_cyc_i,
  input  logic                    m0_wb_stb_i,
  input  logic                    m0_wb_we_i,
  input  logic [3:0]              m0_wb_sel_i,
  input  logic [ADDRESS_SIZE-1:0] m0_wb_adr_i,
  input  logic [31:0]             m0_wb_data_i,
  output logic                    m0_wb_ack_o,
  output logic                    m0_wb_error_o,
  output logic                    m0_wb_stall_o,
  output logic [31:0]             m0_wb_data_o,

  input  logic                    m1_wb_cyc_i,
  input  logic                    m1_wb_stb_i,
  input  logic                    m1_wb_we_i,
  input  logic [3:0]              m1_wb_sel_i,
  input  logic [ADDRESS_SIZE-1:0] m1_wb_adr_i,
  input  logic [31:0]             m1_wb_data_i,
  output logic                    m1_wb_ack_o,
  output logic                    m1_wb_error_o,
  output logic                    m1_wb_stall_o,
  output logic [31:0]             m1_wb_data_o,

  output logic                    s_wb_cyc_o,
  output logic                    s_wb_stb_o,
  output logic                    s_wb_we_o,
  output logic [3:0]              s_wb_sel_o,
  output logic [ADDRESS_SIZE-1:0] s_wb_adr_o,
  output logic [31:0]             s_wb_data_o,
  input  logic                    s_wb_ack_i,
  input  logic                    s_wb_stall_i,
  input  logic                    s_wb_error_i,
  input  logic [31:0]             s_wb_data_i
);

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  arb_state_t              r_state;
  master_idx_t             r_owner;
  logic [ADDRESS_SIZE-1:0] r_adr;
  logic [31:0]             r_wdata;
  logic [3:0]              r_sel;
  logic                    r_we;
  logic [TMO_W-1:0]        r_tmo;
  logic [31:0]             r_rsp_data;
  logic                    r_rsp_err;

  logic        w_req0;
  logic        w_req1;
  logic        w_valid;
  master_idx_t w_winner;
  logic        w_update;
  logic        w_owner_cyc;
  logic        w_slave_rsp;
  logic        w_timeout;
  logic        w_respond;
  logic        w_accept;

  assign w_req0      = m0_wb_cyc_i & m0_wb_stb_i;
  assign w_req1      = m1_wb_cyc_i & m1_wb_stb_i;
  assign w_update    = (r_state == ST_RESPOND);
  assign w_owner_cyc = (r_owner == MASTER_1) ? m1_wb_cyc_i : m0_wb_cyc_i;
  assign w_slave_rsp = s_wb_ack_i | s_wb_error_i;
  assign w_timeout   = (r_tmo == TMO_LIMIT);
  assign w_respond   = (r_state == ST_RESPOND);
  assign w_accept    = (r_state == ST_IDLE) & w_valid;

  cached_memory_wb_arbiter_rr_arbiter2 u_rr_arbiter2 (
    .i_clk    (wb_clk_i),
    .i_rst_n  (wb_rst_i),
    .i_req0   (w_req0),
    .i_req1   (w_req1),
    .i_update (w_update),
    .i_grant  (r_owner),
    .o_valid  (w_valid),
    .o_winner (w_winner)
  );

  // Transaction FSM with request/response registers and timeout counter.
  // Owner drop of cyc is checked first so an abort can never produce a
  // response; a slave response in the timeout cycle still wins over the error.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state    <= ST_IDLE;
      r_owner    <= MASTER_0;
      r_adr      <= '0;
      r_wdata    <= '0;
      r_sel      <= '0;
      r_we       <= 1'b0;
      r_tmo      <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_owner <= w_winner;
            r_adr   <= (w_winner == MASTER_1) ? m1_wb_adr_i  : m0_wb_adr_i;
            r_wdata <= (w_winner == MASTER_1) ? m1_wb_data_i : m0_wb_data_i;
            r_sel   <= (w_winner == MASTER_1) ? m1_wb_sel_i  : m0_wb_sel_i;
            r_we    <= (w_winner == MASTER_1) ? m1_wb_we_i   : m0_wb_we_i;
            r_tmo   <= '0;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE, ST_WAIT: begin
          if (!w_owner_cyc) begin
            r_state <= ST_IDLE;
          end else if (w_slave_rsp) begin
            r_rsp_data <= s_wb_data_i;
            r_rsp_err  <= s_wb_error_i;
            r_state    <= ST_RESPOND;
          end else if (w_timeout) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
            r_state    <= ST_RESPOND;
          end else begin
            r_tmo <= r_tmo + 1'b1;
            if ((r_state == ST_ISSUE) && !s_wb_stall_i) begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_RESPOND: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_wb_cyc_o  = (r_state == ST_ISSUE) | (r_state == ST_WAIT);
  assign s_wb_stb_o  = (r_state == ST_ISSUE);
  assign s_wb_we_o   = r_we;
  assign s_wb_sel_o  = r_sel;
  assign s_wb_adr_o  = r_adr;
  assign s_wb_data_o = r_wdata;

  assign m0_wb_ack_o   = w_respond & (r_owner == MASTER_0) & ~r_rsp_err;
  assign m0_wb_error_o = w_respond & (r_owner == MASTER_0) &  r_rsp_err;
  assign m1_wb_ack_o   = w_respond & (r_owner == MASTER_1) & ~r_rsp_err;
  assign m1_wb_error_o = w_respond & (r_owner == MASTER_1) &  r_rsp_err;

  assign m0_wb_stall_o = ~(w_accept & (w_winner == MASTER_0));
  assign m1_wb_stall_o = ~(w_accept & (w_winner == MASTER_1));

  assign m0_wb_data_o = r_rsp_data;
  assign m1_wb_data_o = r_rsp_data;

endmodule

// File: doc/cached_memory_wb_arbiter.md
# cached_memory_wb_arbiter

Two-master Wishbone arbiter that sits directly upstream of the cached external-memory block. It merges the core instruction-fetch port (master 0) and the data/DMA port (master 1) onto the single pipelined Wishbone slave port of the cached memory. It allows one outstanding transaction at a time, uses round-robin priority, and enforces a response timeout so a hung cache or QSPI cannot stall a master forever.

## Interface
Parameters:
- ADDRESS_SIZE, 24, Wishbone word-address width on all ports.
- TIMEOUT_CYCLES, 255, maximum slave cycles (ISSUE+WAIT) before an error response; 1..255, counter is 8 bits.

Ports (N = 0, 1):
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  reset, asynchronous, active-low.
- mN_wb_cyc_i, mN_wb_stb_i, mN_wb_we_i  in  1 each  master N bus cycle, strobe, write.
- mN_wb_sel_i  in  4  master N byte select.
- mN_wb_adr_i  in  ADDRESS_SIZE  master N address.
- mN_wb_data_i  in  32  master N write data.
- mN_wb_ack_o, mN_wb_error_o  out  1 each  one-cycle response pulses to master N.
- mN_wb_stall_o  out  1  master N stall.
- mN_wb_data_o  out  32  read data; both masters are driven from the shared response register.
- s_wb_cyc_o, s_wb_stb_o, s_wb_we_o  out  1 each  signals to the cached memory.
- s_wb_sel_o  out  4; s_wb_adr_o  out  ADDRESS_SIZE; s_wb_data_o  out  32.
- s_wb_ack_i, s_wb_stall_i, s_wb_error_i  in  1 each; s_wb_data_i  in  32.

## Operation
- Request N = mN_wb_cyc_i & mN_wb_stb_i.
- Winner:
  - only one requester: that master wins;
  - both requesting: the master other than lastGrant wins;
  - lastGrant resets to 1, so master 0 wins the first tie.
- States are IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - stall_o of the winner is 0 (combinational); every other stall_o is 1.
  - On a winning request: latch adr/data/sel/we into the request register, set owner, clear the timeout counter, go to ISSUE.
- ISSUE:
  - s_wb_cyc_o=1, s_wb_stb_o=1, request-register fields driven.
  - When s_wb_stall_i=0: go to WAIT.
  - If s_wb_ack_i or s_wb_error_i arrives in the same cycle, go straight to RESPOND.
- WAIT:
  - s_wb_cyc_o=1, s_wb_stb_o=0.
  - On s_wb_ack_i or s_wb_error_i: capture s_wb_data_i and the error flag, go to RESPOND.
- RESPOND:
  - Owner's ack_o (or error_o) = 1 for exactly one cycle; s_wb_cyc_o=0.
  - lastGrant <= owner; go to IDLE.
- Timeout:
  - Counter increments every cycle in ISSUE or WAIT.
  - At count == TIMEOUT_CYCLES, go to RESPOND with error=1 and response data 0; s_wb_cyc_o drops that cycle.
- Abort:
  - If the owner drops cyc in ISSUE or WAIT, go to IDLE with no response.
  - s_wb_cyc_o is 0 from the next cycle.
  - A late slave ack while in IDLE is ignored.
- Simultaneous s_wb_ack_i and s_wb_error_i: error wins.
- The non-owner sees stall_o=1, ack_o=0 and error_o=0 throughout a transaction.
- Outputs at reset:
  - all s_wb_* = 0; all ack_o/error_o = 0; all data_o = 0;
  - stall_o = 1 (no requests present); state IDLE; owner 0.
- Reset asserted mid-transaction returns to IDLE immediately and drops s_wb_cyc_o asynchronously; no response is issued.

## Timing
- Accept at edge T (IDLE, stall_o low) → s_wb_stb_o high in cycle T+1.
- Slave ack sampled at edge T+k → master ack_o high in cycle T+k+1.
- Minimum latency: accept-to-ack is 3 cycles when the slave has no stall and acks in the cycle after stb.
- Issue rate: at most one transaction per 4 cycles (IDLE, ISSUE, WAIT, RESPOND); 3 cycles when the slave acks during ISSUE.
- All s_wb_* outputs, ack_o, error_o and data_o are registered state decodes; only stall_o is combinational from the requests.
- Timeout error pulse: cycle T+1+TIMEOUT_CYCLES+1 when the slave never responds.

## Structure
- Shared package holds:
  - the state encoding (2-bit IDLE=0, ISSUE=1, WAIT=2, RESPOND=3);
  - the TIMEOUT counter width constant (8);
  - the master-index type.
- One natural sub-module, rr_arbiter2: two request inputs, lastGrant register, winner output and an update strobe.
- The top level holds the request and response registers, the FSM and the timeout counter.

## Test plan
- **Single read.** m0 reads adr 0x000100; slave acks 1 cycle after stb with 0xDEADBEEF → m0_wb_ack_o one cycle at T+3, m0_wb_data_o=0xDEADBEEF; m1 sees no ack.
- **Contention.** m0 and m1 request together three times in a row → grants go m0, m1, m0; the losing master's stall_o stays high until its accept cycle.
- **Slave stall.** s_wb_stall_i held high 5 cycles, write sel=4'b0011, data 0x12345678 → stb held 6 cycles with stable fields; a single ack_o reaches the owner after the slave ack.
- **Timeout.** TIMEOUT_CYCLES=8, slave never responds → error_o pulses at T+10, s_wb_cyc_o low; the next request is accepted normally.
- **Abort and reset.**
  - Owner drops cyc in WAIT, then the slave acks → no ack_o to either master; the arbiter returns to IDLE.
  - wb_rst_i low mid-ISSUE → s_wb_cyc_o=0 immediately and every output is at its reset value.
- **Slave error.** s_wb_error_i and s_wb_ack_i asserted together → owner gets error_o=1 and ack_o=0.
